// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: decoupled MIPS instruction-fetch front end.
// Issues one outstanding request at a time on the addr_ok/data_ok bus.
// Each returned word is buffered with its PC in a circular queue, and
// decode drains the queue through a valid/ready handshake.
// Optional build macro FETCH_BYPASS_EN lets a word arriving at an empty
// queue drive the outputs in the same cycle it returns.
module fetch_queue_unit #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
  parameter int          CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ireq_valid,
  output logic [31:0]      ireq_addr,
  input  logic             iresp_addr_ok,
  input  logic             iresp_data_ok,
  input  logic [31:0]      iresp_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] out_count
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_fetch_pc;
  logic             r_discard;
  logic [31:0]      r_req_addr;
  logic [31:0]      r_req_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_q_pc    [QUEUE_DEPTH];
  logic [31:0]      r_q_instr [QUEUE_DEPTH];

  logic             w_empty;
  logic             w_take;
  logic             w_keep;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic             w_slot;
  logic             w_issue;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_redir_pc;
  logic [31:0]      w_pc_nxt;

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) drop the top three bits;
  // everything else is used as-is.
  function automatic logic [31:0] f_translate(input logic [31:0] pc);
    if (pc[31:30] == 2'b10) begin
      return {3'b000, pc[28:0]};
    end
    return pc;
  endfunction

  // Transaction completion, queue traffic, slot reservation and next fetch PC.
  always_comb begin
    w_empty = (r_count == '0);
    // A word is taken either in WAIT_DATA, or in WAIT_ADDR when the bus
    // accepts and answers in the same cycle; data_ok anywhere else is stale.
    w_take  = ((r_state == WAIT_DATA) && iresp_data_ok) ||
              ((r_state == WAIT_ADDR) && iresp_addr_ok && iresp_data_ok);
    w_keep  = w_take && !r_discard && !redirect_valid;
`ifdef FETCH_BYPASS_EN
    w_byp   = w_empty && w_keep;
`else
    w_byp   = 1'b0;
`endif
    // A bypassed word that decode takes immediately never enters storage.
    w_push  = w_keep && !(w_byp && out_ready);
    // Redirect flushes the queue, so a same-cycle dequeue is meaningless.
    w_pop   = !w_empty && out_ready && !redirect_valid;
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
    // A new request reserves a queue slot up front, so its word always fits.
    w_slot  = (w_count_nxt < CNT_W'(QUEUE_DEPTH));
    w_issue = w_slot && ((r_state == IDLE) || w_take);
    // A misaligned redirect target is a decode error; force word alignment.
    w_redir_pc = redirect_pc & 32'hffff_fffc;
    if (redirect_valid) begin
      w_pc_nxt = w_redir_pc;
    end else if ((r_state == WAIT_ADDR) && iresp_addr_ok && !r_discard) begin
      w_pc_nxt = r_fetch_pc + 32'd4;
    end else begin
      w_pc_nxt = r_fetch_pc;
    end
  end

  // Fetch FSM: request sequencing, fetch PC and squash tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
    end else begin
      r_fetch_pc <= w_pc_nxt;
      // An accepted request cannot be withdrawn; mark its word for dropping.
      if (w_take) begin
        r_discard <= 1'b0;
      end else if (redirect_valid && (r_state != IDLE)) begin
        r_discard <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_slot) begin
            r_state <= WAIT_ADDR;
          end
        end
        WAIT_ADDR: begin
          if (iresp_addr_ok) begin
            if (iresp_data_ok) begin
              r_state <= w_slot ? WAIT_ADDR : IDLE;
            end else begin
              r_state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (iresp_data_ok) begin
            r_state <= w_slot ? WAIT_ADDR : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Capture address and PC of a new request; held stable until accepted.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_req_addr <= f_translate(w_pc_nxt);
      r_req_pc   <= w_pc_nxt;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Queue storage: PC and instruction written at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]    <= r_req_pc;
      r_q_instr[r_tail] <= iresp_data;
    end
  end

  // Head-of-queue view for decode; zeros while nothing is presented.
  always_comb begin
    out_valid = !w_empty || w_byp;
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (!w_empty) begin
      out_pc    = r_q_pc[r_head];
      out_instr = r_q_instr[r_head];
    end else if (w_byp) begin
      out_pc    = r_req_pc;
      out_instr = iresp_data;
    end
  end

  assign ireq_valid = (r_state == WAIT_ADDR);
  assign ireq_addr  = r_req_addr;
  assign out_count  = r_count;

endmodule
